// File: rtl/comparator.sv
// Structural equality comparator for register specifiers: per-bit XNOR feeding a
// fan-in-4 AND tree, plus a registered copy of the result.
`timescale 1ns/10ps
module comparator #(
  parameter int WIDTH      = 5,
  parameter int GATE_DELAY = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  output logic             equal,
  output logic             equal_q
);

  // Node count at tree level l; level 0 holds the XNOR outputs.
  function automatic int level_count(int l);
    int c = WIDTH;
    for (int k = 0; k < l; k++) c = (c + 3) / 4;
    return c;
  endfunction

  function automatic int level_offset(int l);
    int o = 0;
    for (int k = 0; k < l; k++) o += level_count(k);
    return o;
  endfunction

  function automatic int tree_depth();
    int c = WIDTH;
    int d = 0;
    while (c > 1) begin
      c = (c + 3) / 4;
      d++;
    end
    return d;
  endfunction

  localparam int DEPTH = tree_depth();
  localparam int TOTAL = level_offset(DEPTH + 1);

  // All tree levels packed into one vector; the root is the last node.
  wire [TOTAL-1:0] node;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xnor #(GATE_DELAY) u_xnor (node[i], Reg1[i], Reg2[i]);
  end

  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int IN_CNT  = level_count(l);
    localparam int OUT_CNT = level_count(l + 1);
    localparam int IN_OFF  = level_offset(l);
    localparam int OUT_OFF = level_offset(l + 1);

    for (genvar g = 0; g < OUT_CNT; g++) begin : g_grp
      localparam int BASE = IN_OFF + 4 * g;
      localparam int FAN  = (IN_CNT - 4 * g >= 4) ? 4 : (IN_CNT - 4 * g);

      if (FAN == 4) begin : g_and4
        and #(GATE_DELAY) u_and (node[OUT_OFF+g], node[BASE], node[BASE+1],
                                 node[BASE+2], node[BASE+3]);
      end else if (FAN == 3) begin : g_and3
        and #(GATE_DELAY) u_and (node[OUT_OFF+g], node[BASE], node[BASE+1],
                                 node[BASE+2]);
      end else if (FAN == 2) begin : g_and2
        and #(GATE_DELAY) u_and (node[OUT_OFF+g], node[BASE], node[BASE+1]);
      end else begin : g_pass
        // A lone leftover node skips this level and joins the next AND directly.
        assign node[OUT_OFF+g] = node[BASE];
      end
    end
  end

  assign equal = node[TOTAL-1];

  // Registered flag for consumers one stage downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) equal_q <= 1'b0;
    else       equal_q <= equal;
  end

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: combinational sweep plus registered-path
// latency and asynchronous reset behaviour.
`timescale 1ns/10ps
module tb_comparator;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic             equal;
  logic             equal_q;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #50 clk = ~clk;

  comparator #(.WIDTH(WIDTH), .GATE_DELAY(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .Reg1    (reg1),
    .Reg2    (reg2),
    .equal   (equal),
    .equal_q (equal_q)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Compare an observed output against the oldest scoreboard entry.
  task automatic check_sb(input string tag, input logic obs);
    if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, obs, ~obs);
    else                   check_eq(tag, obs, exp_q.pop_front());
  endtask

  task automatic drive_comb(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    reg1 = a;
    reg2 = b;
    exp_q.push_back(a == b);
  endtask

  task automatic comb_step(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    drive_comb(a, b);
    #40;
    check_sb(tag, equal);
  endtask

  initial begin
    reset = 1'b1;
    reg1  = '0;
    reg2  = '0;
    #1;
    check_eq("reset_equal_q", equal_q, 1'b0);

    // X31 detection
    comb_step("x31_match", 5'b11111, 5'b11111);
    comb_step("x31_miss",  5'b11110, 5'b11111);

    // Zeros, then a walking one in reg2
    comb_step("zero_match", 5'b00000, 5'b00000);
    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] w;
      w = '0;
      w[i] = 1'b1;
      comb_step($sformatf("walk_bit%0d", i), 5'b00000, w);
    end
    comb_step("zero_return", 5'b00000, 5'b00000);

    // Exhaustive sweep
    for (int a = 0; a < (1 << WIDTH); a++) begin
      for (int b = 0; b < (1 << WIDTH); b++) begin
        comb_step($sformatf("sweep_%0d_%0d", a, b), WIDTH'(a), WIDTH'(b));
      end
    end

    // Reset held two cycles with matching operands
    @(negedge clk);
    reset = 1'b1;
    reg1  = 5'd7;
    reg2  = 5'd7;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("rst_hold_q_%0d", c), equal_q, 1'b0);
      check_eq($sformatf("rst_hold_eq_%0d", c), equal, 1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_release_pre_edge", equal_q, 1'b0);
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1;
    check_sb("rst_release_q", equal_q);

    // One-cycle latency on equal_q
    @(negedge clk);
    reg1 = 5'd3;
    reg2 = 5'd3;
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1;
    check_sb("lat_edge_n", equal_q);
    reg2 = 5'd4;
    exp_q.push_back(1'b0);
    #40;
    check_eq("lat_hold_before_edge", equal_q, 1'b1);
    @(posedge clk);
    #1;
    check_sb("lat_edge_n1", equal_q);

    // Mid-cycle asynchronous reset
    reg2 = 5'd3;
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1;
    check_sb("async_pre_q", equal_q);
    #20;
    reset = 1'b1;
    exp_q.push_back(1'b0);
    #1;
    check_sb("async_rst_q", equal_q);
    #5;
    reset = 1'b0;

    if (exp_q.size() != 0) check_eq("sb_leftover", 1'b1, exp_q.size() == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
